// File: rtl/toy_bus_arbiter_if.sv
// Bundle of the two master ports and the shared bus port.
// slave: arbiter side. master: masters plus decode/read mux side.
interface toy_bus_arbiter_if;
  logic        i_m0_req;
  logic        i_m0_we;
  logic [15:0] i_m0_addr;
  logic [15:0] i_m0_wdata;
  logic        o_m0_gnt;
  logic        o_m0_ack;
  logic [15:0] o_m0_rdata;
  logic        i_m1_req;
  logic        i_m1_we;
  logic [15:0] i_m1_addr;
  logic [15:0] i_m1_wdata;
  logic        o_m1_gnt;
  logic        o_m1_ack;
  logic [15:0] o_m1_rdata;
  logic [15:0] o_bus_addr;
  logic        o_bus_we;
  logic [15:0] o_bus_wdata;
  logic [15:0] i_bus_rdata;

  modport slave (
    input  i_m0_req, i_m0_we,
    input  i_m0_addr, i_m0_wdata,
    output o_m0_gnt, o_m0_ack,
    output o_m0_rdata,
    input  i_m1_req, i_m1_we,
    input  i_m1_addr, i_m1_wdata,
    output o_m1_gnt, o_m1_ack,
    output o_m1_rdata,
    output o_bus_addr, o_bus_we,
    output o_bus_wdata,
    input  i_bus_rdata
  );

  modport master (
    output i_m0_req, i_m0_we,
    output i_m0_addr, i_m0_wdata,
    input  o_m0_gnt, o_m0_ack,
    input  o_m0_rdata,
    output i_m1_req, i_m1_we,
    output i_m1_addr, i_m1_wdata,
    input  o_m1_gnt, o_m1_ack,
    input  o_m1_rdata,
    input  o_bus_addr, o_bus_we,
    input  o_bus_wdata,
    output i_bus_rdata
  );
endinterface

// File: rtl/toy_bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded bursts.
// Ports: i_clk, i_reset (async high), bus (slave modport).
module toy_bus_arbiter #(
  parameter int MAX_BURST  = 4,
  parameter int FIRST_PRIO = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  toy_bus_arbiter_if.slave   bus
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT =
    CW'(MAX_BURST - 1);
  localparam logic PRIO = FIRST_PRIO[0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_ack0;
  logic            r_ack1;
  logic [15:0]     r_rdata0;
  logic [15:0]     r_rdata1;
  logic            w_beat0;
  logic            w_beat1;
  logic            w_limit;

  assign w_beat0 = (r_state == GNT0) & bus.i_m0_req;
  assign w_beat1 = (r_state == GNT1) & bus.i_m1_req;
  assign w_limit = (r_cnt == LAST_BEAT);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.i_m0_req && bus.i_m1_req)
          w_next = r_last ? GNT0 : GNT1;
        else if (bus.i_m0_req)
          w_next = GNT0;
        else if (bus.i_m1_req)
          w_next = GNT1;
      end
      GNT0: begin
        if (!bus.i_m0_req)
          w_next = bus.i_m1_req ? GNT1 : IDLE;
        else if (bus.i_m1_req && w_limit)
          w_next = GNT1;
      end
      GNT1: begin
        if (!bus.i_m1_req)
          w_next = bus.i_m0_req ? GNT0 : IDLE;
        else if (bus.i_m0_req && w_limit)
          w_next = GNT0;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_last   <= ~PRIO;
      r_cnt    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      // Saturation only matters for a lone master;
      // with contention the limit forces a switch.
      if (w_next != r_state)
        r_cnt <= '0;
      else if ((w_beat0 | w_beat1) && !w_limit)
        r_cnt <= r_cnt + 1'b1;
      if (w_next == GNT0 && r_state != GNT0)
        r_last <= 1'b0;
      else if (w_next == GNT1 && r_state != GNT1)
        r_last <= 1'b1;
      r_ack0 <= w_beat0;
      r_ack1 <= w_beat1;
      if (w_beat0)
        r_rdata0 <= bus.i_bus_rdata;
      if (w_beat1)
        r_rdata1 <= bus.i_bus_rdata;
    end
  end

  assign bus.o_m0_gnt   = (r_state == GNT0);
  assign bus.o_m1_gnt   = (r_state == GNT1);
  assign bus.o_m0_ack   = r_ack0;
  assign bus.o_m1_ack   = r_ack1;
  assign bus.o_m0_rdata = r_rdata0;
  assign bus.o_m1_rdata = r_rdata1;

  always_comb begin
    bus.o_bus_addr  = '0;
    bus.o_bus_we    = 1'b0;
    bus.o_bus_wdata = '0;
    unique case (1'b1)
      w_beat0: begin
        bus.o_bus_addr  = bus.i_m0_addr;
        bus.o_bus_we    = bus.i_m0_we;
        bus.o_bus_wdata = bus.i_m0_wdata;
      end
      w_beat1: begin
        bus.o_bus_addr  = bus.i_m1_addr;
        bus.o_bus_we    = bus.i_m1_we;
        bus.o_bus_wdata = bus.i_m1_wdata;
      end
      default: ;
    endcase
  end
endmodule
